// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and gate register map for the scan sequencer
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_DWELL  = 3'd4,
    S_CLEAR  = 3'd5,
    S_FINISH = 3'd6
  } scan_state_t;

  localparam logic [7:0] GATE_CMD_ADDR = 8'h20;
  localparam logic [7:0] GATE_ERR_ADDR = 8'h21;
  localparam logic [7:0] GATE_SEL_ADDR = 8'h22;

endpackage

// File: rtl/pulse_counter.sv
// rtl/pulse_counter.sv - synchronized rising-edge counter with saturation
module pulse_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 clr,
  input  logic                 pulse_in,
  output logic [CNT_WIDTH-1:0] count
);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 rise;

  // an edge is seen on the third clock after pulse_in rises
  assign rise  = sync2_q & ~prev_q;
  assign count = count_q;

  // two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // count detected edges, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (res || clr) begin
      count_q <= '0;
    end else if (rise && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - walks enabled gate channels, dwelling on each for a count of generator pulses
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [CNT_WIDTH-1:0]  dwell,
  input  logic [NUM_CH-1:0]     keys,
  input  logic                  gen_in,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  we,
  output logic [3:0]            cur_ch,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // pointer must hold NUM_CH+1 after the last channel
  localparam int PW = $clog2(NUM_CH + 2);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  scan_state_t          state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ch_q;
  logic [SW-1:0]        settle_q;
  logic                 wrote_q;
  logic                 aborted_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                 we_q;
  logic [3:0]           cur_ch_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic                 found;
  logic                 any_en;
  logic [PW-1:0]        found_ch;
  logic                 to_clear;
  logic                 cnt_clr;
  logic [CNT_WIDTH-1:0] cnt;

  // dwell counter only runs in DWELL, so it starts from zero on every entry
  assign cnt_clr = (state_q != S_DWELL);

  pulse_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_pulse_counter (
    .clk     (clk),
    .res     (res),
    .clr     (cnt_clr),
    .pulse_in(gen_in),
    .count   (cnt)
  );

  // lowest enabled channel at or above the search pointer; descending scan lets the lowest win
  always_comb begin
    found    = 1'b0;
    any_en   = 1'b0;
    found_ch = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (!keys[i-1]) begin
        any_en = 1'b1;
        if (PW'(i) >= ptr_q) begin
          found    = 1'b1;
          found_ch = PW'(i);
        end
      end
    end
  end

  // stop aborts from any active scan state; SELECT also falls into CLEAR when nothing is left
  always_comb begin
    to_clear = 1'b0;
    unique case (state_q)
      S_SELECT:                    to_clear = stop || (!found && !(loop && any_en));
      S_WRITE, S_SETTLE, S_DWELL:  to_clear = stop;
      default:                     to_clear = 1'b0;
    endcase
  end

  // scan FSM; bus outputs are loaded on entry to WRITE/CLEAR and zeroed otherwise
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(1);
      ch_q      <= '0;
      settle_q  <= '0;
      wrote_q   <= 1'b0;
      aborted_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      cur_ch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (to_clear) begin
        state_q  <= S_CLEAR;
        we_q     <= 1'b1;
        addr_q   <= DATA_WIDTH'(GATE_SEL_ADDR);
        cur_ch_q <= '0;
        if (stop) begin
          aborted_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_SELECT;
              ptr_q     <= PW'(1);
              busy_q    <= 1'b1;
              wrote_q   <= 1'b0;
              aborted_q <= 1'b0;
            end
          end
          S_SELECT: begin
            if (found) begin
              state_q  <= S_WRITE;
              ch_q     <= found_ch;
              we_q     <= 1'b1;
              addr_q   <= DATA_WIDTH'(GATE_SEL_ADDR);
              data_q   <= DATA_WIDTH'(found_ch);
              cur_ch_q <= 4'(found_ch);
              wrote_q  <= 1'b1;
            end else begin
              ptr_q <= PW'(1);
            end
          end
          S_WRITE: begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
          end
          S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              state_q <= S_DWELL;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          S_DWELL: begin
            if (cnt == dwell) begin
              ptr_q   <= ch_q + 1'b1;
              state_q <= S_SELECT;
            end
          end
          S_CLEAR: begin
            state_q <= S_FINISH;
            done_q  <= wrote_q && !aborted_q;
            err_q   <= !wrote_q && !aborted_q;
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign addr     = addr_q;
  assign data_out = data_q;
  assign we       = we_q;
  assign cur_ch   = cur_ch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized self-checking bench for scan_sequencer
module tb_scan_sequencer;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic        stop;
  logic        loop;
  logic [15:0] dwell;
  logic [9:0]  keys;
  logic        gen_in;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic        we;
  logic [3:0]  cur_ch;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic gen_auto = 1'b0;
  int   kick_req = 0;
  int   kick_done;
  logic mon_clr  = 1'b0;

  int cyc = 0;
  int wq[$];
  int aq[$];
  int cq[$];
  int tq[$];
  int n_done = 0;
  int n_err  = 0;
  int n_busy = 0;
  int n_viol = 0;

  int exp_wr[$];
  int exp_done;
  int exp_err;

  scan_sequencer #(
    .DATA_WIDTH(8),
    .NUM_CH    (10),
    .CNT_WIDTH (16),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .dwell   (dwell),
    .keys    (keys),
    .gen_in  (gen_in),
    .addr    (addr),
    .data_out(data_out),
    .we      (we),
    .cur_ch  (cur_ch),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // generator pulses: random free-running train, or single requested pulses
  initial begin
    gen_in    = 1'b0;
    kick_done = 0;
    forever begin
      @(posedge clk);
      #3;
      if (gen_auto) begin
        gen_in = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #3 gen_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end else if (kick_done != kick_req) begin
        gen_in = 1'b1;
        repeat (2) @(posedge clk);
        #3 gen_in = 1'b0;
        kick_done++;
      end
    end
  end

  // bus monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      wq.delete();
      aq.delete();
      cq.delete();
      tq.delete();
      n_done <= 0;
      n_err  <= 0;
      n_busy <= 0;
      n_viol <= 0;
    end else begin
      if (we) begin
        wq.push_back(int'(data_out));
        aq.push_back(int'(addr));
        cq.push_back(int'(cur_ch));
        tq.push_back(cyc);
      end
      if (!we && (addr != 8'h00 || data_out != 8'h00)) n_viol <= n_viol + 1;
      if (done) n_done <= n_done + 1;
      if (err)  n_err  <= n_err + 1;
      if (busy) n_busy <= n_busy + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // a non-looping scan writes every enabled channel in ascending order, then 0
  function automatic void model_scan(input logic [9:0] k);
    exp_wr.delete();
    for (int ch = 1; ch <= 10; ch++) begin
      if (k[ch-1] == 1'b0) exp_wr.push_back(ch);
    end
    exp_done = (exp_wr.size() > 0) ? 1 : 0;
    exp_err  = 1 - exp_done;
    exp_wr.push_back(0);
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_scan(input string tag);
    chk_eq({tag, "_nwr"}, wq.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wq.size(); i++) begin
      chk_eq($sformatf("%s_data%0d", tag, i), wq[i], exp_wr[i]);
      chk_eq($sformatf("%s_addr%0d", tag, i), aq[i], 32'h22);
      chk_eq($sformatf("%s_cur%0d", tag, i), cq[i], exp_wr[i]);
    end
    chk_eq({tag, "_done"}, n_done, exp_done);
    chk_eq({tag, "_err"}, n_err, exp_err);
    chk_eq({tag, "_idlebus"}, n_viol, 0);
  endtask

  task automatic run_scan(input string tag, input logic [9:0] k, input logic [15:0] dw);
    keys  = k;
    dwell = dw;
    loop  = 1'b0;
    model_scan(k);
    clear_mon();
    pulse_start();
    wait_idle(tag);
    check_scan(tag);
  endtask

  task automatic wait_ch(input string tag, input logic [3:0] ch);
    int n;
    n = 0;
    while (cur_ch != ch && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, cur_ch, ch);
  endtask

  initial begin
    res   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    dwell = '0;
    keys  = '1;

    // reset state, with start asserted to show reset wins
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("rst_addr", addr, 0);
    chk_eq("rst_data", data_out, 0);
    chk_eq("rst_we", we, 0);
    chk_eq("rst_cur", cur_ch, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_err", err, 0);
    start = 1'b0;
    res   = 1'b0;

    // channels 1 and 3, dwell 3
    gen_auto = 1'b1;
    run_scan("two_ch", 10'b1111111010, 16'd3);

    // nothing enabled: single clear write and an err pulse
    run_scan("none", 10'b1111111111, 16'd2);
    chk_eq("none_busy", n_busy, 3);

    // dwell 0 on channel 5: clear write follows after settle, one dwell cycle and a select cycle
    run_scan("dw0", 10'b1111101111, 16'd0);
    if (tq.size() == 2) chk_eq("dw0_gap", tq[1] - tq[0], SETTLE + 3);

    // random key patterns and dwell counts
    for (int it = 0; it < 8; it++) begin
      logic [9:0] k;
      k = 10'($urandom);
      if (it == 3) k = 10'b1111111111;
      if (it == 5) k = 10'b0000000000;
      run_scan($sformatf("rnd%0d", it), k, 16'($urandom_range(0, 3)));
    end

    // abort in DWELL on channel 2 after one of two pulses
    gen_auto = 1'b0;
    keys  = 10'b1111111101;
    dwell = 16'd2;
    loop  = 1'b0;
    clear_mon();
    pulse_start();
    wait_ch("stop_ch2", 4'd2);
    repeat (SETTLE + 2) @(posedge clk);
    #1 kick_req++;
    repeat (8) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk_eq("stop_we", we, 1);
    chk_eq("stop_addr", addr, 32'h22);
    chk_eq("stop_data", data_out, 0);
    chk_eq("stop_cur", cur_ch, 0);
    @(posedge clk);
    #1;
    chk_eq("stop_fin_done", done, 0);
    chk_eq("stop_fin_err", err, 0);
    @(posedge clk);
    #1;
    chk_eq("stop_busy", busy, 0);
    @(negedge clk);
    #1;
    exp_wr.delete();
    exp_wr.push_back(2);
    exp_wr.push_back(0);
    exp_done = 0;
    exp_err  = 0;
    check_scan("stop");

    // looping over channels 9 and 10 until stopped
    gen_auto = 1'b1;
    keys  = 10'b0011111111;
    dwell = 16'd1;
    loop  = 1'b1;
    clear_mon();
    pulse_start();
    begin
      int n;
      n = 0;
      while (wq.size() < 5 && n < 20000) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle("loop");
    loop = 1'b0;
    chk_eq("loop_enough", {31'd0, wq.size() >= 6}, 32'd1);
    if (wq.size() > 0) chk_eq("loop_last", wq[wq.size()-1], 0);
    for (int i = 0; i + 1 < wq.size(); i++) begin
      chk_eq($sformatf("loop_wr%0d", i), wq[i], (i % 2 == 0) ? 9 : 10);
    end
    chk_eq("loop_done", n_done, 0);
    chk_eq("loop_err", n_err, 0);

    // reset during SETTLE: outputs clear, no clear write, next scan starts at channel 1
    keys  = 10'b1111111011;
    dwell = 16'd2;
    clear_mon();
    pulse_start();
    wait_ch("rs_ch3", 4'd3);
    @(posedge clk);
    #1 res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    chk_eq("rs_addr", addr, 0);
    chk_eq("rs_data", data_out, 0);
    chk_eq("rs_we", we, 0);
    chk_eq("rs_cur", cur_ch, 0);
    chk_eq("rs_busy", busy, 0);
    chk_eq("rs_done", done, 0);
    chk_eq("rs_err", err, 0);
    clear_mon();
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    chk_eq("rs_quiet", wq.size(), 0);
    run_scan("after_rs", 10'b1111110110, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
